// File: rtl/reg_host_bridge.sv
// Host byte-stream command decoder acting as bus initiator for the register file.
// Define REG_HOST_BRIDGE_CHKSUM_EN to require a trailing XOR checksum byte on every frame.
module reg_host_bridge #(
  parameter int RD_TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        rstb,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data,
  output logic        rx_ready,
  output logic        tx_valid,
  output logic [7:0]  tx_data,
  input  logic        tx_ready,
  output logic        wr_en,
  output logic [3:0]  be,
  output logic [15:0] wr_addr,
  output logic [31:0] wdata,
  output logic        rd_en,
  output logic [15:0] rd_addr,
  input  logic [31:0] rdata,
  input  logic        rd_rdy,
  output logic        busy,
  output logic [7:0]  err_cnt
);

  typedef enum logic [3:0] {
    S_CMD, S_ADDR_H, S_ADDR_L, S_DATA, S_CHK,
    S_ISSUE_WR, S_ISSUE_RD, S_WAIT_RD, S_RESP, S_NAK
  } state_t;

  localparam logic [3:0] OP_WR    = 4'h1;
  localparam logic [3:0] OP_RD    = 4'h2;
  localparam logic [7:0] ACK_BYTE = 8'h5A;
  localparam logic [7:0] NAK_BYTE = 8'hEE;
  localparam logic [7:0] TMO_LAST = 8'(RD_TIMEOUT - 1);

  state_t      state;
  logic        is_wr;
  logic [3:0]  be_q;
  logic [15:0] addr_q;
  logic [23:0] data_q;   // D3..D1; D0 goes straight to the bus or is parked in d0_q
  logic [23:0] rd_q;     // remaining read bytes, next one in [23:16]
  logic [1:0]  cnt;
  logic [7:0]  tmr;
  logic        rx_fire;
  logic        tx_fire;

  assign rx_fire = rx_valid & rx_ready;
  assign tx_fire = tx_valid & tx_ready;

`ifdef REG_HOST_BRIDGE_CHKSUM_EN
  logic [7:0] chk;
  logic [7:0] d0_q;

  // Running XOR of every byte accepted so far in the current frame.
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      chk <= 8'h00;
    end else if (rx_fire) begin
      chk <= (state == S_CMD) ? rx_data : (chk ^ rx_data);
    end
  end
`endif

  // NOTE: every register here, bus-side holding registers included, gets an async reset value;
  // there is no storage array, so nothing is exempt.
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      state    <= S_CMD;
      rx_ready <= 1'b0;
      tx_valid <= 1'b0;
      tx_data  <= 8'h00;
      wr_en    <= 1'b0;
      be       <= 4'h0;
      wr_addr  <= 16'h0000;
      wdata    <= 32'h0;
      rd_en    <= 1'b0;
      rd_addr  <= 16'h0000;
      busy     <= 1'b0;
      err_cnt  <= 8'h00;
      is_wr    <= 1'b0;
      be_q     <= 4'h0;
      addr_q   <= 16'h0000;
      data_q   <= 24'h0;
      rd_q     <= 24'h0;
      cnt      <= 2'd0;
      tmr      <= 8'h00;
`ifdef REG_HOST_BRIDGE_CHKSUM_EN
      d0_q     <= 8'h00;
`endif
    end else begin
      wr_en <= 1'b0;
      rd_en <= 1'b0;
      case (state)
        S_CMD: begin
          rx_ready <= 1'b1;  // also raises rx_ready on the first clock after reset
          if (rx_fire) begin
            be_q  <= rx_data[3:0];
            is_wr <= (rx_data[7:4] == OP_WR);
            busy  <= 1'b1;
            if (rx_data[7:4] == OP_WR || rx_data[7:4] == OP_RD) begin
              state <= S_ADDR_H;
            end else begin
              state    <= S_NAK;
              rx_ready <= 1'b0;
              tx_valid <= 1'b1;
              tx_data  <= NAK_BYTE;
              err_cnt  <= err_cnt + {7'd0, err_cnt != 8'hFF};
            end
          end
        end
        S_ADDR_H: if (rx_fire) begin
          addr_q[15:8] <= rx_data;
          state        <= S_ADDR_L;
        end
        S_ADDR_L: if (rx_fire) begin
          addr_q[7:0] <= rx_data;
          cnt         <= 2'd0;
`ifdef REG_HOST_BRIDGE_CHKSUM_EN
          state <= is_wr ? S_DATA : S_CHK;
`else
          if (is_wr) begin
            state <= S_DATA;
          end else begin
            state    <= S_ISSUE_RD;
            rx_ready <= 1'b0;
            rd_en    <= 1'b1;
            rd_addr  <= {addr_q[15:8], rx_data};
          end
`endif
        end
        S_DATA: if (rx_fire) begin
          cnt <= cnt + 2'd1;
          if (cnt != 2'd3) begin
            data_q <= {data_q[15:0], rx_data};
          end else begin
`ifdef REG_HOST_BRIDGE_CHKSUM_EN
            d0_q  <= rx_data;
            state <= S_CHK;
`else
            state    <= S_ISSUE_WR;
            rx_ready <= 1'b0;
            wr_en    <= 1'b1;
            wr_addr  <= addr_q;
            be       <= be_q;
            wdata    <= {data_q, rx_data};
`endif
          end
        end
`ifdef REG_HOST_BRIDGE_CHKSUM_EN
        S_CHK: if (rx_fire) begin
          rx_ready <= 1'b0;
          if (rx_data != chk) begin
            state    <= S_NAK;
            tx_valid <= 1'b1;
            tx_data  <= NAK_BYTE;
            err_cnt  <= err_cnt + {7'd0, err_cnt != 8'hFF};
          end else if (is_wr) begin
            state   <= S_ISSUE_WR;
            wr_en   <= 1'b1;
            wr_addr <= addr_q;
            be      <= be_q;
            wdata   <= {data_q, d0_q};
          end else begin
            state   <= S_ISSUE_RD;
            rd_en   <= 1'b1;
            rd_addr <= addr_q;
          end
        end
`endif
        S_ISSUE_WR: begin
          state    <= S_RESP;
          tx_valid <= 1'b1;
          tx_data  <= ACK_BYTE;
        end
        S_ISSUE_RD: begin
          state <= S_WAIT_RD;
          tmr   <= 8'h00;
        end
        S_WAIT_RD: begin
          if (rd_rdy) begin
            state    <= S_RESP;
            rd_q     <= rdata[23:0];
            tx_valid <= 1'b1;
            tx_data  <= rdata[31:24];
            cnt      <= 2'd0;
          end else if (tmr == TMO_LAST) begin
            state    <= S_NAK;
            tx_valid <= 1'b1;
            tx_data  <= NAK_BYTE;
            err_cnt  <= err_cnt + {7'd0, err_cnt != 8'hFF};
          end else begin
            tmr <= tmr + 8'd1;
          end
        end
        S_RESP: if (tx_fire) begin
          if (is_wr || cnt == 2'd3) begin
            state    <= S_CMD;
            tx_valid <= 1'b0;
            rx_ready <= 1'b1;
            busy     <= 1'b0;
          end else begin
            cnt     <= cnt + 2'd1;
            tx_data <= rd_q[23:16];
            rd_q    <= {rd_q[15:0], 8'h00};
          end
        end
        S_NAK: if (tx_fire) begin
          state    <= S_CMD;
          tx_valid <= 1'b0;
          rx_ready <= 1'b1;
          busy     <= 1'b0;
        end
        default: begin
          state <= S_CMD;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_reg_host_bridge.sv
// Scoreboard bench for reg_host_bridge: random frames against a queue/array reference model.
// Honours REG_HOST_BRIDGE_CHKSUM_EN by appending the XOR checksum byte to every frame.
module tb_reg_host_bridge;

  localparam int RD_TIMEOUT = 15;

  logic        clk = 1'b0;
  logic        rstb;
  logic        rx_valid;
  logic [7:0]  rx_data;
  logic        rx_ready;
  logic        tx_valid;
  logic [7:0]  tx_data;
  logic        tx_ready;
  logic        wr_en;
  logic [3:0]  be;
  logic [15:0] wr_addr;
  logic [31:0] wdata;
  logic        rd_en;
  logic [15:0] rd_addr;
  logic [31:0] rdata;
  logic        rd_rdy;
  logic        busy;
  logic [7:0]  err_cnt;

  always #5 clk = ~clk;

  reg_host_bridge #(.RD_TIMEOUT(RD_TIMEOUT)) dut (
    .clk(clk), .rstb(rstb),
    .rx_valid(rx_valid), .rx_data(rx_data), .rx_ready(rx_ready),
    .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready),
    .wr_en(wr_en), .be(be), .wr_addr(wr_addr), .wdata(wdata),
    .rd_en(rd_en), .rd_addr(rd_addr), .rdata(rdata), .rd_rdy(rd_rdy),
    .busy(busy), .err_cnt(err_cnt)
  );

  typedef struct packed {
    logic [15:0] addr;
    logic [3:0]  be;
    logic [31:0] data;
  } wr_t;

  wr_t         exp_wr[$];
  logic [15:0] exp_rd[$];
  logic [7:0]  exp_tx[$];
  logic [7:0]  frm[$];
  logic [31:0] ref_mem[int];
  logic [31:0] rf_mem[int];

  int n_vec = 0;
  int n_bad = 0;
  int ref_err = 0;
  int exp_lat = 0;
  int cyc = 0;
  int strobe_cyc = 0;
  int wc = 0;
  bit no_rdy = 1'b0;
  bit stall_mode = 1'b0;
  bit chk_bad = 1'b0;
  bit pend = 1'b0;
  logic [15:0] pend_addr;
  logic tv_prev = 1'b0;
  logic stall_prev = 1'b0;
  logic [7:0] data_prev;
  wr_t mon_e;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                        input logic [3:0] b);
    logic [31:0] r;
    r = old;
    for (int i = 0; i < 4; i++) if (b[i]) r[i*8 +: 8] = d[i*8 +: 8];
    return r;
  endfunction

  function automatic logic [31:0] ref_get(input logic [15:0] a);
    return ref_mem.exists(int'(a)) ? ref_mem[int'(a)] : 32'h0;
  endfunction

  function automatic logic [31:0] rf_get(input logic [15:0] a);
    return rf_mem.exists(int'(a)) ? rf_mem[int'(a)] : 32'h0;
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Register-file stand-in: rd_rdy one cycle after rd_en, writes applied on wr_en.
  initial begin
    rd_rdy = 1'b0;
    rdata  = 32'h0;
    forever begin
      @(posedge clk);
      #1;
      rd_rdy = 1'b0;
      rdata  = $urandom;
      if (!rstb) begin
        pend = 1'b0;
      end else begin
        if (pend) begin
          rd_rdy = 1'b1;
          rdata  = rf_get(pend_addr);
          pend   = 1'b0;
        end
        if (rd_en && !no_rdy) begin
          pend      = 1'b1;
          pend_addr = rd_addr;
        end
        if (wr_en) rf_mem[int'(wr_addr)] = merge(rf_get(wr_addr), wdata, be);
      end
    end
  end

  // TX sink: random back-pressure, or exactly 5 stall cycles per byte in stall mode.
  initial begin
    tx_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (stall_mode) begin
        if (!tx_valid) begin
          tx_ready = 1'b0;
          wc = 0;
        end else if (wc == 5) begin
          tx_ready = 1'b1;
          wc = 0;
        end else begin
          tx_ready = 1'b0;
          wc++;
        end
      end else begin
        tx_ready = ($urandom_range(0, 3) != 0);
      end
    end
  end

  // Monitor: pops the scoreboard whenever the DUT presents a strobe or a TX handshake.
  initial begin
    forever begin
      @(negedge clk);
      if (rstb) begin
        if (wr_en) begin
          strobe_cyc = cyc;
          if (exp_wr.size() == 0) begin
            check("unexpected wr_en", 32'(wr_addr), 32'hFFFF_FFFF);
          end else begin
            mon_e = exp_wr.pop_front();
            check("wr_addr", 32'(wr_addr), 32'(mon_e.addr));
            check("be", 32'(be), 32'(mon_e.be));
            check("wdata", wdata, mon_e.data);
          end
        end
        if (rd_en) begin
          strobe_cyc = cyc;
          if (exp_rd.size() == 0) check("unexpected rd_en", 32'(rd_addr), 32'hFFFF_FFFF);
          else check("rd_addr", 32'(rd_addr), 32'(exp_rd.pop_front()));
        end
        if (tx_valid && !tv_prev && exp_lat > 0) begin
          check("strobe to tx_valid latency", 32'(cyc - strobe_cyc), 32'(exp_lat));
          exp_lat = 0;
        end
        if (tx_valid) check("rx_ready while responding", 32'(rx_ready), 32'h0);
        if (tx_valid && stall_prev) check("tx_data stable", 32'(tx_data), 32'(data_prev));
        if (tx_valid && tx_ready) begin
          if (exp_tx.size() == 0) check("unexpected tx byte", 32'(tx_data), 32'h100);
          else check("tx byte", 32'(tx_data), 32'(exp_tx.pop_front()));
        end
        tv_prev    = tx_valid;
        stall_prev = tx_valid && !tx_ready;
        data_prev  = tx_data;
      end else begin
        tv_prev    = 1'b0;
        stall_prev = 1'b0;
      end
    end
  end

  task automatic nak_inc();
    if (ref_err < 255) ref_err++;
  endtask

  task automatic send_byte(input logic [7:0] b);
    int k;
    rx_valid = 1'b1;
    rx_data  = b;
    for (k = 0; k < 100; k++) begin
      @(negedge clk);
      if (rx_ready) break;
    end
    if (k == 100) check("rx_ready wait", 32'(rx_ready), 32'h1);
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
    rx_data  = 8'($urandom);
  endtask

  task automatic send_frm();
`ifdef REG_HOST_BRIDGE_CHKSUM_EN
    logic [7:0] c;
    c = 8'h00;
    foreach (frm[i]) c ^= frm[i];
    frm.push_back(chk_bad ? (c ^ 8'h01) : c);
`endif
    foreach (frm[i]) send_byte(frm[i]);
  endtask

  task automatic wait_done();
    int k;
    for (k = 0; k < 1000; k++) begin
      @(negedge clk);
      if (exp_tx.size() == 0 && !busy) break;
    end
    if (k == 1000) check("response wait", 32'(exp_tx.size()), 32'h0);
    check("err_cnt", 32'(err_cnt), 32'(ref_err));
    check("pending strobes", 32'(exp_wr.size() + exp_rd.size()), 32'h0);
    @(posedge clk);
    #1;
  endtask

  task automatic build_write(input logic [15:0] a, input logic [3:0] b, input logic [31:0] d);
    frm.delete();
    frm.push_back({4'h1, b});
    frm.push_back(a[15:8]);
    frm.push_back(a[7:0]);
    for (int i = 3; i >= 0; i--) frm.push_back(d[i*8 +: 8]);
  endtask

  task automatic do_write(input logic [15:0] a, input logic [3:0] b, input logic [31:0] d);
    build_write(a, b, d);
    exp_wr.push_back(wr_t'{addr: a, be: b, data: d});
    ref_mem[int'(a)] = merge(ref_get(a), d, b);
    exp_tx.push_back(8'h5A);
    exp_lat = 1;
    send_frm();
    wait_done();
  endtask

  task automatic do_read(input logic [15:0] a, input bit timeout);
    logic [31:0] v;
    frm.delete();
    frm.push_back({4'h2, 4'($urandom)});
    frm.push_back(a[15:8]);
    frm.push_back(a[7:0]);
    exp_rd.push_back(a);
    no_rdy = timeout;
    if (timeout) begin
      exp_tx.push_back(8'hEE);
      nak_inc();
      exp_lat = RD_TIMEOUT + 1;
    end else begin
      v = ref_get(a);
      for (int i = 3; i >= 0; i--) exp_tx.push_back(v[i*8 +: 8]);
      exp_lat = 2;
    end
    send_frm();
    wait_done();
    no_rdy = 1'b0;
  endtask

  task automatic do_bad(input logic [7:0] cmd);
    exp_tx.push_back(8'hEE);
    nak_inc();
    exp_lat = 0;
    send_byte(cmd);
    wait_done();
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, " ctrl outputs"},
          32'({rx_ready, tx_valid, tx_data, wr_en, be, rd_en, busy, err_cnt}), 32'h0);
    check({tag, " wr_addr"}, 32'(wr_addr), 32'h0);
    check({tag, " wdata"}, wdata, 32'h0);
    check({tag, " rd_addr"}, 32'(rd_addr), 32'h0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [7:0]  op;
    logic [15:0] a;
    int          sel;

    rstb     = 1'b0;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    rstb = 1'b1;
    @(posedge clk);
    #1;
    check("rx_ready after reset", 32'(rx_ready), 32'h1);

    // Directed frames from the test plan.
    do_write(16'h0004, 4'hF, 32'hDEADBEEF);
    do_write(16'h000C, 4'hF, 32'h00000ABC);
    do_read(16'h000C, 1'b0);
    do_bad(8'h70);
    do_read(16'h0004, 1'b1);
    do_read(16'h0004, 1'b0);
    stall_mode = 1'b1;
    do_read(16'h000C, 1'b0);
    stall_mode = 1'b0;
    do_write(16'h0020, 4'h0, 32'h12345678);
    do_read(16'h0020, 1'b0);

`ifdef REG_HOST_BRIDGE_CHKSUM_EN
    build_write(16'h0030, 4'hF, 32'hCAFEF00D);
    chk_bad = 1'b1;
    exp_tx.push_back(8'hEE);
    nak_inc();
    exp_lat = 0;
    send_frm();
    wait_done();
    chk_bad = 1'b0;
    do_read(16'h0030, 1'b0);
    do_write(16'h0030, 4'hF, 32'hCAFEF00D);
    do_read(16'h0030, 1'b0);
`endif

    // Reset while the bridge waits for ADDR_L: the partial frame must vanish.
    send_byte(8'h1F);
    send_byte(8'h00);
    rx_valid = 1'b1;
    rx_data  = 8'h40;
    rstb     = 1'b0;
    #2;
    rx_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs("mid-frame reset");
    ref_err = 0;
    exp_lat = 0;
    rstb    = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    do_write(16'h0040, 4'h5, 32'hA5A5A5A5);
    do_read(16'h0040, 1'b0);

    // Randomised mix over a small address pool so reads hit earlier writes.
    for (int i = 0; i < 60; i++) begin
      sel = $urandom_range(0, 19);
      a   = 16'h1000 + 16'($urandom_range(0, 7));
      if (sel < 9) begin
        do_write(a, 4'($urandom_range(0, 15)), $urandom);
      end else if (sel < 17) begin
        stall_mode = (sel == 16);
        do_read(a, 1'b0);
        stall_mode = 1'b0;
      end else if (sel == 17) begin
        do op = 8'($urandom); while (op[7:4] == 4'h1 || op[7:4] == 4'h2);
        do_bad(op);
      end else begin
        do_read(a, 1'b1);
      end
    end

    // Drive the error counter into saturation.
    for (int i = 0; i < 256; i++) begin
      do op = 8'($urandom); while (op[7:4] == 4'h1 || op[7:4] == 4'h2);
      do_bad(op);
    end
    do_read(16'h0004, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
